hazard_controller: RTL and testbench

- Pipeline sequencing controller for the 5-stage SIMD AES core (F/D/E/M/W).
- Drives the fetch-stage and pipeline-register enables and flushes: StallF, StallD, StallE, FlushD, FlushE, FlushM.
- Detects load-use hazards, PC-write hazards and taken branches.
- Holds a vector instruction in Execute for VEC_BEATS cycles while the lane datapath processes the 128-bit state in beats, and keeps a saturating stall-cycle counter for performance debug.

---
 rtl/hazard_controller.sv | 146 ++++++++++++++
 tb/tb_hazard_controller.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller for the 5-stage SIMD AES core: stall/flush
// generation for load-use, PC-write and branch hazards plus multi-beat vector hold.
module hazard_controller #(
  parameter int VEC_BEATS = 4,
  parameter int CNT_W     = 16,
  localparam int BEAT_W   = (VEC_BEATS > 1) ? $clog2(VEC_BEATS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        RA1D,
  input  logic [3:0]        RA2D,
  input  logic [3:0]        WA3E,
  input  logic              RegWriteE,
  input  logic              MemtoRegE,
  input  logic              VecE,
  input  logic              BranchTakenE,
  input  logic              PCSrcD,
  input  logic              PCSrcE,
  input  logic              PCSrcM,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic [BEAT_W-1:0] BeatE,
  output logic              VecBusy,
  output logic [CNT_W-1:0]  StallCnt
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(VEC_BEATS - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [BEAT_W-1:0]  r_beat;
  logic [BEAT_W-1:0]  w_beat_nxt;
  logic [CNT_W-1:0]   r_stall_cnt;
  logic               w_vec_hold;
  logic               w_lw_stall;
  logic               w_pc_pend;
  logic               w_stall_f;
  logic               w_stall_d;
  logic               w_stall_e;
  logic               w_flush_d;
  logic               w_flush_e;
  logic               w_flush_m;

  assign w_lw_stall = MemtoRegE & RegWriteE & ((WA3E == RA1D) | (WA3E == RA2D));
  assign w_pc_pend  = PCSrcD | PCSrcE | PCSrcM;

  // Vector-hold sequencer: next state, next beat and the hold request
  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_vec_hold  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (VecE && (VEC_BEATS > 1)) begin
          w_vec_hold  = 1'b1;
          w_state_nxt = ST_RUN;
          w_beat_nxt  = BEAT_W'(1);
        end else begin
          w_beat_nxt  = '0;
        end
      end
      ST_RUN: begin
        // VecE is ignored here; the last beat releases the pipeline
        if (r_beat < LAST_BEAT) begin
          w_vec_hold  = 1'b1;
          w_beat_nxt  = r_beat + BEAT_W'(1);
        end else begin
          w_state_nxt = ST_IDLE;
          w_beat_nxt  = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_beat_nxt  = '0;
      end
    endcase
  end

  // Prioritised stall/flush outputs; reset forces the free-running defaults
  always_comb begin
    w_stall_f = 1'b1;
    w_stall_d = 1'b1;
    w_stall_e = 1'b1;
    w_flush_d = 1'b0;
    w_flush_e = 1'b0;
    w_flush_m = 1'b0;
    if (!rst) begin
      w_stall_f = 1'b1;
    end else if (w_vec_hold) begin
      w_stall_f = 1'b0;
      w_stall_d = 1'b0;
      w_stall_e = 1'b0;
      w_flush_m = 1'b1;
    end else if (BranchTakenE) begin
      w_flush_d = 1'b1;
      w_flush_e = 1'b1;
    end else begin
      w_stall_f = ~(w_lw_stall | w_pc_pend);
      w_stall_d = ~w_lw_stall;
      w_flush_e = w_lw_stall;
      w_flush_d = w_pc_pend & ~w_lw_stall;
    end
  end

  // Sequencer state and beat registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_beat  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
    end
  end

  // Saturating count of cycles with the fetch stage held
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (!w_stall_f && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  assign StallF   = w_stall_f;
  assign StallD   = w_stall_d;
  assign StallE   = w_stall_e;
  assign FlushD   = w_flush_d;
  assign FlushE   = w_flush_e;
  assign FlushM   = w_flush_m;
  assign VecBusy  = rst & w_vec_hold;
  assign BeatE    = r_beat;
  assign StallCnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: default build, a 4-bit counter build
// for saturation, and a VEC_BEATS=1 build that must never hold.
module tb_hazard_controller;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] RA1D, RA2D, WA3E;
  logic RegWriteE, MemtoRegE, VecE, BranchTakenE, PCSrcD, PCSrcE, PCSrcM;

  logic a_sf, a_sd, a_se, a_fd, a_fe, a_fm, a_busy;
  logic [1:0]  a_beat;
  logic [15:0] a_cnt;
  logic b_sf, b_sd, b_se, b_fd, b_fe, b_fm, b_busy;
  logic [1:0]  b_beat;
  logic [3:0]  b_cnt;
  logic c_sf, c_sd, c_se, c_fd, c_fe, c_fm, c_busy;
  logic [0:0]  c_beat;
  logic [15:0] c_cnt;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  hazard_controller #(.VEC_BEATS(4), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .RA1D(RA1D), .RA2D(RA2D), .WA3E(WA3E),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .VecE(VecE),
    .BranchTakenE(BranchTakenE), .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM),
    .StallF(a_sf), .StallD(a_sd), .StallE(a_se), .FlushD(a_fd), .FlushE(a_fe),
    .FlushM(a_fm), .BeatE(a_beat), .VecBusy(a_busy), .StallCnt(a_cnt));

  hazard_controller #(.VEC_BEATS(4), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .RA1D(RA1D), .RA2D(RA2D), .WA3E(WA3E),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .VecE(VecE),
    .BranchTakenE(BranchTakenE), .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM),
    .StallF(b_sf), .StallD(b_sd), .StallE(b_se), .FlushD(b_fd), .FlushE(b_fe),
    .FlushM(b_fm), .BeatE(b_beat), .VecBusy(b_busy), .StallCnt(b_cnt));

  hazard_controller #(.VEC_BEATS(1), .CNT_W(16)) dut_c (
    .clk(clk), .rst(rst), .RA1D(RA1D), .RA2D(RA2D), .WA3E(WA3E),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .VecE(VecE),
    .BranchTakenE(BranchTakenE), .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM),
    .StallF(c_sf), .StallD(c_sd), .StallE(c_se), .FlushD(c_fd), .FlushE(c_fe),
    .FlushM(c_fm), .BeatE(c_beat), .VecBusy(c_busy), .StallCnt(c_cnt));

  // {StallF,StallD,StallE,FlushD,FlushE,FlushM}
  wire [5:0] a_out = {a_sf, a_sd, a_se, a_fd, a_fe, a_fm};
  wire [5:0] b_out = {b_sf, b_sd, b_se, b_fd, b_fe, b_fm};
  wire [5:0] c_out = {c_sf, c_sd, c_se, c_fd, c_fe, c_fm};

  typedef struct {
    string      name;
    logic [3:0] ra1, ra2, wa3;
    logic       regw, memreg, br, pcd, pce, pcm;
    logic [5:0] exp_out;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic clear_inputs();
    RA1D = 4'd0; RA2D = 4'd0; WA3E = 4'd0;
    RegWriteE = 1'b0; MemtoRegE = 1'b0; VecE = 1'b0; BranchTakenE = 1'b0;
    PCSrcD = 1'b0; PCSrcE = 1'b0; PCSrcM = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b0;
    #1;
    rst = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{"idle",        4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b111000};
    tbl[1]  = '{"lw_ra2",      4'd1, 4'd5, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b001010};
    tbl[2]  = '{"lw_ra1",      4'd5, 4'd2, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b001010};
    tbl[3]  = '{"lw_nomatch",  4'd6, 4'd6, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b111000};
    tbl[4]  = '{"lw_noregw",   4'd5, 4'd5, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b111000};
    tbl[5]  = '{"pc_d",        4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'b011100};
    tbl[6]  = '{"pc_e",        4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'b011100};
    tbl[7]  = '{"pc_m",        4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'b011100};
    tbl[8]  = '{"pc_and_lw",   4'd3, 4'd0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'b001010};
    tbl[9]  = '{"br_masks_lw", 4'd3, 4'd0, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'b111110};
    tbl[10] = '{"br_with_pc",  4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'b111110};

    clear_inputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_out", {26'd0, a_out}, {26'd0, 6'b111000});
    chk("reset_busy_beat", {29'd0, a_busy, a_beat}, 32'd0);
    chk("reset_cnt", {16'd0, a_cnt}, 32'd0);
    chk("reset_cnt_small", {28'd0, b_cnt}, 32'd0);
    rst = 1'b1;

    // Idle-state vectors; each held across one rising edge
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      RA1D = tbl[i].ra1; RA2D = tbl[i].ra2; WA3E = tbl[i].wa3;
      RegWriteE = tbl[i].regw; MemtoRegE = tbl[i].memreg; BranchTakenE = tbl[i].br;
      PCSrcD = tbl[i].pcd; PCSrcE = tbl[i].pce; PCSrcM = tbl[i].pcm;
      #1;
      chk(tbl[i].name, {26'd0, a_out}, {26'd0, tbl[i].exp_out});
    end
    @(negedge clk);
    clear_inputs();
    #1;
    chk("table_cnt", {16'd0, a_cnt}, 32'd6);
    chk("table_no_busy", {31'd0, a_busy}, 32'd0);

    // Vector hold: 3 frozen cycles then release on beat 3
    pulse_reset();
    @(negedge clk);
    VecE = 1'b1;
    #1;
    chk("vec_b0_out", {26'd0, a_out}, {26'd0, 6'b000001});
    chk("vec_b0_beat_busy", {29'd0, a_busy, a_beat}, {29'd0, 1'b1, 2'd0});
    chk("vb1_no_hold", {25'd0, c_busy, c_out}, {25'd0, 1'b0, 6'b111000});
    for (int b = 1; b < 3; b++) begin
      @(negedge clk);
      #1;
      chk("vec_hold_out", {26'd0, a_out}, {26'd0, 6'b000001});
      chk("vec_hold_beat", {29'd0, a_busy, a_beat}, {29'd0, 1'b1, 2'(b)});
    end
    @(negedge clk);
    #1;
    chk("vec_rel_out", {26'd0, a_out}, {26'd0, 6'b111000});
    chk("vec_rel_beat", {29'd0, a_busy, a_beat}, {29'd0, 1'b0, 2'd3});
    @(negedge clk);
    VecE = 1'b0;
    #1;
    chk("vec_cnt", {16'd0, a_cnt}, 32'd3);
    chk("vec_back_idle", {29'd0, a_busy, a_beat}, 32'd0);
    chk("vb1_cnt", {16'd0, c_cnt}, 32'd0);

    // Vector wins over branch and PC write; release beat obeys branch priority
    @(negedge clk);
    VecE = 1'b1; BranchTakenE = 1'b1; PCSrcM = 1'b1;
    #1;
    chk("prio_vec_out", {26'd0, a_out}, {26'd0, 6'b000001});
    chk("prio_vec_busy", {31'd0, a_busy}, 32'd1);
    chk("vb1_branch", {26'd0, c_out}, {26'd0, 6'b111110});
    @(negedge clk);
    BranchTakenE = 1'b0; PCSrcM = 1'b0;
    @(negedge clk);
    @(negedge clk);
    BranchTakenE = 1'b1;
    #1;
    chk("rel_branch_out", {26'd0, a_out}, {26'd0, 6'b111110});
    chk("rel_branch_beat", {29'd0, a_busy, a_beat}, {29'd0, 1'b0, 2'd3});
    @(negedge clk);
    clear_inputs();

    // Reset in the middle of a run
    pulse_reset();
    @(negedge clk);
    VecE = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("mid_run_beat", {30'd0, a_beat}, 32'd2);
    PCSrcM = 1'b1;
    rst = 1'b0;
    #1;
    chk("rst_mid_out", {26'd0, a_out}, {26'd0, 6'b111000});
    chk("rst_mid_busy_beat", {29'd0, a_busy, a_beat}, 32'd0);
    chk("rst_mid_cnt", {16'd0, a_cnt}, 32'd0);
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("post_rst_out", {26'd0, a_out}, {26'd0, 6'b111000});
    chk("post_rst_idle", {29'd0, a_busy, a_beat}, 32'd0);

    // Counter saturation on the 4-bit build
    pulse_reset();
    @(negedge clk);
    PCSrcM = 1'b1;
    repeat (20) @(negedge clk);
    PCSrcM = 1'b0;
    #1;
    chk("sat_cnt_small", {28'd0, b_cnt}, 32'd15);
    chk("sat_cnt_wide", {16'd0, a_cnt}, 32'd20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
